trp_feeder: RTL and testbench

TRP_FEEDER -- requirements
Module: trp_feeder

---
 rtl/trp_pkg.sv | 14 +
 rtl/trp_res_fifo.sv | 56 +++++
 rtl/trp_feeder.sv | 144 ++++++++++++++
 tb/tb_trp_feeder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trp_pkg.sv
// Shared definitions for the reduction feeder slice.
//   state_t        : feeder transaction state
//   RES_FIFO_DEPTH : number of result entries buffered ahead of the consumer
package trp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int unsigned RES_FIFO_DEPTH = 2;

endpackage

// File: rtl/trp_res_fifo.sv
// Small result FIFO between the feeder and the result consumer.
//   clk, reset : clock, asynchronous active-high reset
//   push       : write push_data at the tail
//   pop        : drop the head entry
//   head_data  : head entry (zero when empty)
//   count      : number of valid entries
module trp_res_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q <= (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/trp_feeder.sv
// Feeds one vector at a time, element by element, into a reduction unit and
// buffers the reduction results (or timeout markers) for a consumer.
//   clk, reset                  : clock, asynchronous active-high reset
//   vec_valid/ready/data/len/mode : vector input handshake
//   trp_en/a/mode               : element strobe, element, latched mode
//   trp_busy/valid/out          : reduction unit back-pressure and result
//   res_valid/ready/data/err    : buffered result output (err = timeout)
module trp_feeder
  import trp_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned NUM_ELEMS = 8,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          vec_valid,
  output logic                          vec_ready,
  input  logic [NUM_ELEMS*WIDTH-1:0]    vec_data,
  input  logic [$clog2(NUM_ELEMS):0]    vec_len,
  input  logic [1:0]                    vec_mode,
  output logic                          trp_en,
  output logic [WIDTH-1:0]              trp_a,
  output logic [1:0]                    trp_mode,
  input  logic                          trp_busy,
  input  logic                          trp_valid,
  input  logic [WIDTH-1:0]              trp_out,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [WIDTH-1:0]              res_data,
  output logic                          res_err
);

  localparam int unsigned LW  = $clog2(NUM_ELEMS) + 1;
  localparam int unsigned CW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned FCW = $clog2(RES_FIFO_DEPTH + 1);

  state_t                     state_q, state_d;
  logic [LW-1:0]              idx_q, len_q, len_eff;
  logic [CW-1:0]              cnt_q;
  logic [NUM_ELEMS*WIDTH-1:0] data_q;
  logic [1:0]                 mode_q;

  logic                       accept, issue_last, timeout_hit;
  logic                       push, pop;
  logic [WIDTH:0]             push_word, head_word;
  logic [FCW-1:0]             fifo_count;

  // Zero or oversized lengths mean a full vector.
  assign len_eff = ((vec_len == '0) || (vec_len > LW'(NUM_ELEMS))) ? LW'(NUM_ELEMS) : vec_len;

  assign vec_ready   = (state_q == ST_IDLE) && (fifo_count < FCW'(RES_FIFO_DEPTH));
  assign accept      = vec_valid && vec_ready;
  assign issue_last  = trp_en && (idx_q == (len_q - LW'(1)));
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (issue_last) state_d = ST_WAIT;
      ST_WAIT:  if (trp_valid || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    trp_en    = 1'b0;
    trp_a     = '0;
    push      = 1'b0;
    push_word = '0;
    if (state_q == ST_ISSUE) begin
      trp_en = !trp_busy;
      for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
        if (idx_q == LW'(i)) trp_a = data_q[i*WIDTH +: WIDTH];
      end
    end
    if (state_q == ST_WAIT) begin
      // A real result wins over a timeout landing in the same cycle.
      if (trp_valid) begin
        push      = 1'b1;
        push_word = {1'b0, trp_out};
      end else if (timeout_hit) begin
        push      = 1'b1;
        push_word = {1'b1, {WIDTH{1'b0}}};
      end
    end
  end

  // Transaction datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      mode_q <= '0;
    end else begin
      if (accept) begin
        data_q <= vec_data;
        mode_q <= vec_mode;
        len_q  <= len_eff;
        idx_q  <= '0;
      end else if (trp_en) begin
        idx_q <= idx_q + LW'(1);
      end
      if (issue_last) begin
        cnt_q <= '0;
      end else if ((state_q == ST_WAIT) && !trp_valid && !timeout_hit) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign trp_mode = mode_q;

  assign pop = res_valid && res_ready;

  trp_res_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (RES_FIFO_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .head_data (head_word),
    .count     (fifo_count)
  );

  assign res_valid = (fifo_count != '0);
  assign res_data  = head_word[WIDTH-1:0];
  assign res_err   = head_word[WIDTH];

endmodule

// File: tb/tb_trp_feeder.sv
module tb_trp_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        vec_valid;
  logic        vec_ready;
  logic [31:0] vec_data;
  logic [3:0]  vec_len;
  logic [1:0]  vec_mode;
  logic        trp_en;
  logic [3:0]  trp_a;
  logic [1:0]  trp_mode;
  logic        trp_busy;
  logic        trp_valid;
  logic [3:0]  trp_out;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_data;
  logic        res_err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  trp_feeder #(
    .WIDTH     (4),
    .NUM_ELEMS (8),
    .TIMEOUT   (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .vec_len   (vec_len),
    .vec_mode  (vec_mode),
    .trp_en    (trp_en),
    .trp_a     (trp_a),
    .trp_mode  (trp_mode),
    .trp_busy  (trp_busy),
    .trp_valid (trp_valid),
    .trp_out   (trp_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  len;
    logic [1:0]  mode;
    int unsigned exp_len;
    logic [3:0]  out;
    int unsigned delay;
  } vec_t;

  typedef struct {
    logic       busy;
    logic       tv;
    logic       en;
    logic [3:0] a;
  } bcyc_t;

  vec_t  tbl [6];
  bcyc_t bt  [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Offer a vector in the current cycle, check every issued element, then
  // deliver the reduction result after `delay` idle WAIT cycles.  Returns at
  // the negedge of the cycle following the push.
  task automatic run_vec(input logic [31:0] data, input logic [3:0] len,
                         input logic [1:0] mode, input int unsigned exp_len,
                         input logic [3:0] out, input int unsigned delay);
    vec_data  = data;
    vec_len   = len;
    vec_mode  = mode;
    vec_valid = 1'b1;
    #1 chk("accept_ready", vec_ready, 1);
    tick();
    vec_valid = 1'b0;
    vec_data  = '0;
    vec_mode  = 2'b00;
    for (int unsigned k = 0; k < exp_len; k++) begin
      #1;
      chk("issue_en", trp_en, 1);
      chk("issue_a", trp_a, data[k*4 +: 4]);
      chk("issue_mode", trp_mode, mode);
      tick();
    end
    for (int unsigned d = 0; d < delay; d++) begin
      #1 chk("wait_en", trp_en, 0);
      tick();
    end
    trp_valid = 1'b1;
    trp_out   = out;
    #1;
    chk("wait_en_last", trp_en, 0);
    chk("wait_mode", trp_mode, mode);
    tick();
    trp_valid = 1'b0;
    trp_out   = '0;
  endtask

  task automatic pop_one();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    tbl[0] = '{data: 32'h87654321, len: 4'd8,  mode: 2'b01, exp_len: 8, out: 4'hA, delay: 3};
    tbl[1] = '{data: 32'hFEDCBA98, len: 4'd0,  mode: 2'b10, exp_len: 8, out: 4'h5, delay: 0};
    tbl[2] = '{data: 32'h0000000C, len: 4'd1,  mode: 2'b11, exp_len: 1, out: 4'h3, delay: 1};
    tbl[3] = '{data: 32'h12345ABC, len: 4'd3,  mode: 2'b00, exp_len: 3, out: 4'hF, delay: 2};
    tbl[4] = '{data: 32'h0F1E2D3C, len: 4'd9,  mode: 2'b01, exp_len: 8, out: 4'h7, delay: 0};
    tbl[5] = '{data: 32'h13579BDF, len: 4'd15, mode: 2'b10, exp_len: 8, out: 4'h1, delay: 1};

    bt[0] = '{busy: 1'b0, tv: 1'b0, en: 1'b1, a: 4'h1};
    bt[1] = '{busy: 1'b1, tv: 1'b0, en: 1'b0, a: 4'h2};
    bt[2] = '{busy: 1'b1, tv: 1'b0, en: 1'b0, a: 4'h2};
    bt[3] = '{busy: 1'b0, tv: 1'b0, en: 1'b1, a: 4'h2};
    bt[4] = '{busy: 1'b0, tv: 1'b1, en: 1'b1, a: 4'h3};
    bt[5] = '{busy: 1'b0, tv: 1'b0, en: 1'b1, a: 4'h4};

    reset     = 1'b1;
    vec_valid = 1'b0;
    vec_data  = '0;
    vec_len   = '0;
    vec_mode  = '0;
    trp_busy  = 1'b0;
    trp_valid = 1'b0;
    trp_out   = '0;
    res_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_trp_en", trp_en, 0);
    chk("rst_trp_a", trp_a, 0);
    chk("rst_trp_mode", trp_mode, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_vec_ready", vec_ready, 1);
    tick();
    reset = 1'b0;
    #1 chk("post_rst_vec_ready", vec_ready, 1);

    // Stray trp_valid while idle
    trp_valid = 1'b1;
    trp_out   = 4'hB;
    tick();
    trp_valid = 1'b0;
    #1;
    chk("idle_stray_res_valid", res_valid, 0);
    chk("idle_stray_trp_en", trp_en, 0);

    // Table-driven transactions with immediate pop
    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i].data, tbl[i].len, tbl[i].mode, tbl[i].exp_len, tbl[i].out, tbl[i].delay);
      #1;
      chk("res_valid", res_valid, 1);
      chk("res_data", res_data, tbl[i].out);
      chk("res_err", res_err, 0);
      chk("res_vec_ready", vec_ready, 1);
      chk("res_mode_hold", trp_mode, tbl[i].mode);
      pop_one();
      #1 chk("res_popped", res_valid, 0);
    end

    // Back-pressure mid-ISSUE, stray trp_valid during ISSUE, then timeout
    vec_data  = 32'h00004321;
    vec_len   = 4'd4;
    vec_mode  = 2'b10;
    vec_valid = 1'b1;
    #1 chk("busy_accept_ready", vec_ready, 1);
    tick();
    vec_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      trp_busy  = bt[c].busy;
      trp_valid = bt[c].tv;
      trp_out   = 4'h9;
      #1;
      chk("busy_en", trp_en, bt[c].en);
      chk("busy_a", trp_a, bt[c].a);
      tick();
    end
    trp_busy  = 1'b0;
    trp_valid = 1'b0;
    trp_out   = '0;
    #1;
    chk("busy_wait_en", trp_en, 0);
    chk("busy_no_stray_push", res_valid, 0);
    chk("busy_wait_ready", vec_ready, 0);
    repeat (31) tick();
    #1;
    chk("to_not_yet", res_valid, 0);
    chk("to_not_yet_ready", vec_ready, 0);
    tick();
    #1;
    chk("to_res_valid", res_valid, 1);
    chk("to_res_data", res_data, 0);
    chk("to_res_err", res_err, 1);
    chk("to_idle_ready", vec_ready, 1);
    chk("to_mode_hold", trp_mode, 2'b10);
    pop_one();
    #1 chk("to_popped", res_valid, 0);

    // Two results held back: buffer fills, vec_ready drops, order preserved
    run_vec(32'h00000001, 4'd1, 2'b00, 1, 4'h1, 0);
    #1;
    chk("full1_res_data", res_data, 4'h1);
    chk("full1_ready", vec_ready, 1);
    run_vec(32'h00000021, 4'd2, 2'b11, 2, 4'h2, 0);
    #1;
    chk("full2_ready", vec_ready, 0);
    chk("full2_head", res_data, 4'h1);
    vec_valid = 1'b1;
    vec_data  = 32'h00000009;
    vec_len   = 4'd1;
    tick();
    #1;
    chk("full_no_accept", trp_en, 0);
    chk("full_still_not_ready", vec_ready, 0);
    res_ready = 1'b1;
    #1 chk("full_ready_before_pop", vec_ready, 0);
    tick();
    res_ready = 1'b0;
    vec_valid = 1'b0;
    #1;
    chk("after_pop_ready", vec_ready, 1);
    chk("after_pop_head", res_data, 4'h2);
    chk("after_pop_err", res_err, 0);
    pop_one();
    #1 chk("full_drained", res_valid, 0);

    // Reset mid-ISSUE with a result still buffered
    run_vec(32'h00000005, 4'd1, 2'b10, 1, 4'h5, 0);
    #1 chk("pre_rst_res_valid", res_valid, 1);
    vec_data  = 32'h87654321;
    vec_len   = 4'd8;
    vec_mode  = 2'b01;
    vec_valid = 1'b1;
    tick();
    vec_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("rst_seq_a", trp_a, c + 1);
      tick();
    end
    #1 chk("rst_seq_a_idx3", trp_a, 4'h4);
    reset = 1'b1;
    #1;
    chk("midrst_trp_en", trp_en, 0);
    chk("midrst_trp_a", trp_a, 0);
    chk("midrst_trp_mode", trp_mode, 0);
    chk("midrst_res_valid", res_valid, 0);
    chk("midrst_res_data", res_data, 0);
    chk("midrst_res_err", res_err, 0);
    chk("midrst_vec_ready", vec_ready, 1);
    tick();
    reset     = 1'b0;
    trp_valid = 1'b1;
    trp_out   = 4'h6;
    tick();
    trp_valid = 1'b0;
    #1;
    chk("postrst_stray_res_valid", res_valid, 0);
    chk("postrst_trp_en", trp_en, 0);
    tick();
    #1;
    chk("postrst_res_valid2", res_valid, 0);
    chk("postrst_ready", vec_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
